// File: rtl/bcd_conv_pkg.sv
// bcd_conv_pkg
//   Shared definitions for the BCD conversion blocks: converter state
//   encoding, BCD nibble constants and a helper that sizes a binary result
//   for a given digit count.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } bcd_state_e;

    localparam int BCD_NIBBLE_W  = 4;
    localparam int BCD_MAX_DIGIT = 9;

    // Width needed to hold any value below 10^digits, i.e. ceil(log2(10^digits)).
    function automatic int max_bin_w(input int digits);
        longint p;
        int     w;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        w = 0;
        for (int k = 0; k < 40; k++) begin
            if ((longint'(1) << w) < p) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10
//   Combinational multiply-by-ten-and-add step for decimal accumulation.
//   Returns the full-width acc*10 + digit (no truncation) so the caller can
//   decide how to handle the top bits, plus a flag for a non-decimal digit.
// Ports
//   i_acc            accumulator in (ACC_W bits)
//   i_digit          BCD digit in (4 bits)
//   o_wide           acc*10 + digit, ACC_W+4 bits
//   o_digit_invalid  digit greater than 9
module bcd_mac10
    import bcd_conv_pkg::*;
#(
    parameter int ACC_W = 14
) (
    input  logic [ACC_W-1:0]              i_acc,
    input  logic [BCD_NIBBLE_W-1:0]       i_digit,
    output logic [ACC_W+BCD_NIBBLE_W-1:0] o_wide,
    output logic                          o_digit_invalid
);

    logic [ACC_W+BCD_NIBBLE_W-1:0] w_acc_ext;
    logic [ACC_W+BCD_NIBBLE_W-1:0] w_digit_ext;

    // 4 extra bits are enough: (2^ACC_W - 1)*10 + 15 < 16 * 2^ACC_W.
    assign w_acc_ext   = {{BCD_NIBBLE_W{1'b0}}, i_acc};
    assign w_digit_ext = {{ACC_W{1'b0}}, i_digit};

    // x*10 = x*8 + x*2
    assign o_wide          = (w_acc_ext << 3) + (w_acc_ext << 1) + w_digit_ext;
    assign o_digit_invalid = (i_digit > BCD_NIBBLE_W'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential packed-BCD to unsigned binary converter. Accepts a DIGITS-wide
//   packed BCD word, folds in one digit per clock (MSD first) as
//   acc = acc*10 + d, then presents the result until the consumer takes it.
//   Any digit above 9 sets a sticky error and forces the result to 0.
//   Optional overflow reporting is built when BCDTOBIN_OVF_EN is defined;
//   otherwise out_ovf is tied low and no check logic exists.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, in_bcd packed BCD (MSD at top)
//   out_valid/out_ready  output handshake
//   out_bin              binary result (0 when out_err)
//   out_err              some digit was > 9
//   out_ovf              result did not fit in BIN_W (feature-dependent)
//   busy                 converting or holding a result
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new word
// ST_CONV | folding one digit per clock into the accumulator
// ST_DONE | result presented, waiting for out_ready
module bcd_to_bin_seq
    import bcd_conv_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BCD_NIBBLE_W*DIGITS-1:0] in_bcd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIN_W-1:0]               out_bin,
    output logic                           out_err,
    output logic                           out_ovf,
    output logic                           busy
);

    localparam int SHIFT_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_e                    r_state;
    bcd_state_e                    w_state_next;
    logic [SHIFT_W-1:0]            r_shift;
    logic [BIN_W-1:0]              r_acc;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_err;
    logic                          w_load;
    logic                          w_step;
    logic                          w_last;
    logic [BCD_NIBBLE_W-1:0]       w_digit;
    logic [BIN_W+BCD_NIBBLE_W-1:0] w_wide;
    logic                          w_digit_invalid;

    assign w_digit = r_shift[SHIFT_W-1 -: BCD_NIBBLE_W];
    assign w_last  = (r_cnt == CNT_W'(DIGITS - 1));

    bcd_mac10 #(
        .ACC_W (BIN_W)
    ) u_mac10 (
        .i_acc           (r_acc),
        .i_digit         (w_digit),
        .o_wide          (w_wide),
        .o_digit_invalid (w_digit_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_shift <= in_bcd;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_step) begin
            r_shift <= r_shift << BCD_NIBBLE_W;
            r_acc   <= w_wide[BIN_W-1:0];
            r_cnt   <= r_cnt + 1'b1;
            r_err   <= r_err | w_digit_invalid;
        end
    end

    // Invalid words read as 0 rather than a partial accumulation.
    assign out_bin = (out_valid && !r_err) ? r_acc : '0;
    assign out_err = out_valid & r_err;

`ifdef BCDTOBIN_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_ovf <= 1'b0;
        end else if (w_step) begin
            r_ovf <= r_ovf | (|w_wide[BIN_W+BCD_NIBBLE_W-1:BIN_W]);
        end
    end

    assign out_ovf = out_valid & r_ovf;
`else
    // Carry-out bits have no consumer without overflow reporting.
    logic w_unused_carry;
    assign w_unused_carry = ^w_wide[BIN_W+BCD_NIBBLE_W-1:BIN_W];
    assign out_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic        out_err;
    logic        out_ovf;
    logic        busy;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_bcd;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_bin;
    logic        b_out_err;
    logic        b_out_ovf;
    logic        b_busy;

    logic        c_in_valid;
    logic        c_in_ready;
    logic [11:0] c_in_bcd;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [7:0]  c_out_bin;
    logic        c_out_err;
    logic        c_out_ovf;
    logic        c_busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BCDTOBIN_OVF_EN
    localparam logic EXP_OVF_300 = 1'b1;
`else
    localparam logic EXP_OVF_300 = 1'b0;
`endif

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_err(out_err), .out_ovf(out_ovf), .busy(busy)
    );

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(8)) u_dut_d2 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bcd(b_in_bcd),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bin(b_out_bin),
        .out_err(b_out_err), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) u_dut_d3 (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bcd(c_in_bcd),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bin(c_out_bin),
        .out_err(c_out_err), .out_ovf(c_out_ovf), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word on the 4-digit instance and check the presented result.
    // With out_ready=1 also checks the return to IDLE on the next edge.
    task automatic run_word(input string tag, input logic [15:0] bcd,
                            input logic [13:0] exp_bin, input logic exp_err);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_bcd   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, {30'd0, in_ready, busy}, 32'b01);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd4);
        check_eq({tag, "_bin"}, 32'(out_bin), 32'(exp_bin));
        check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check_eq({tag, "_ovf"}, 32'(out_ovf), 32'd0);
        if (out_ready) begin
            tick();
            check_eq({tag, "_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
        end
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_bcd      = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_bcd    = '0;
        b_out_ready = 1'b1;
        c_in_valid  = 1'b0;
        c_in_bcd    = '0;
        c_out_ready = 1'b1;
        tick();
        rst = 1'b0;

        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_bin",   32'(out_bin),   32'd0);
        check_eq("rst_out_err",   32'(out_err),   32'd0);
        check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);

        run_word("w1234", 16'h1234, 14'd1234, 1'b0);
        run_word("w9999", 16'h9999, 14'd9999, 1'b0);
        run_word("w0000", 16'h0000, 14'd0,    1'b0);
        run_word("w12A4", 16'h12A4, 14'd0,    1'b1);
        run_word("w0042", 16'h0042, 14'd42,   1'b0);

        // Backpressure: result held, new words refused.
        out_ready = 1'b0;
        run_word("bp0815", 16'h0815, 14'd815, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            in_bcd   = 16'h3333;
            tick();
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_bin",   32'(out_bin),   32'd815);
            check_eq("bp_hold_err",   32'(out_err),   32'd0);
            check_eq("bp_in_ready",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
        tick();
        check_eq("bp_no_ghost", {30'd0, out_valid, busy}, 32'b00);

        // Reset while cnt==2 during 5678.
        in_bcd   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_state",
                 {26'd0, out_valid, in_ready, busy, out_err, out_ovf, 1'b0},
                 32'b010000);
        check_eq("mid_rst_bin", 32'(out_bin), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) n++;
        end
        check_eq("mid_rst_no_result", 32'(n), 32'd0);
        run_word("w0007", 16'h0007, 14'd7, 1'b0);

        // Two-digit instance: legacy mapping.
        b_in_bcd   = 8'h15;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("d2_latency", 32'(n), 32'd2);
        check_eq("d2_bin", 32'(b_out_bin), 32'd15);
        check_eq("d2_err", 32'(b_out_err), 32'd0);
        check_eq("d2_ovf", 32'(b_out_ovf), 32'd0);

        // Three-digit instance into 8 bits: 300 = 0x12C, truncated to 0x2C.
        c_in_bcd   = 12'h300;
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        n = 0;
        while (!c_out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("d3_latency", 32'(n), 32'd3);
        check_eq("d3_bin", 32'(c_out_bin), 32'h2C);
        check_eq("d3_err", 32'(c_out_err), 32'd0);
        check_eq("d3_ovf", 32'(c_out_ovf), 32'(EXP_OVF_300));
        tick();
        check_eq("d3_idle", {30'd0, c_out_valid, c_in_ready}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
